// File: rtl/layer_sequencer.sv
// Sequences one inference run: optional per-layer weight load, partial-sum clear,
// watchdog-guarded compute, and advance across NUM_LAYERS layers.
module layer_sequencer #(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst_overall_n,
  input  logic                          start,
  input  logic                          load_weights,
  input  logic                          abort,
  input  logic                          wt_valid,
  output logic                          wt_ready,
  input  logic                          layer_done,
  output logic [$clog2(ROWS)-1:0]       row_sel,
  output logic                          train_en,
  output logic                          rst_vals,
  output logic                          en,
  output logic [$clog2(NUM_LAYERS)-1:0] layer_idx,
  output logic                          busy,
  output logic                          run_done,
  output logic                          timeout_err
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned LW = $clog2(NUM_LAYERS);
  localparam int unsigned WW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_ROW = 3'd1,
    LOAD_GAP = 3'd2,
    CLEAR    = 3'd3,
    COMPUTE  = 3'd4,
    NEXT     = 3'd5,
    FINISH   = 3'd6,
    ERROR    = 3'd7
  } state_t;

  state_t         state;
  state_t         nxt;
  logic [RW-1:0]  row_q;
  logic [LW-1:0]  layer_q;
  logic [WW-1:0]  wd_q;
  logic           load_q;

  logic last_row;
  logic last_layer;
  logic wd_last;

  assign last_row   = (row_q == RW'(ROWS - 1));
  assign last_layer = (layer_q == LW'(NUM_LAYERS - 1));
  assign wd_last    = (wd_q == WW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_overall_n) begin
    if (!rst_overall_n) state <= IDLE;
    else                state <= nxt;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) nxt = load_weights ? LOAD_ROW : CLEAR;
        LOAD_ROW: if (wt_valid) nxt = LOAD_GAP;
        LOAD_GAP: nxt = last_row ? CLEAR : LOAD_ROW;
        CLEAR:    nxt = COMPUTE;
        COMPUTE: begin
          if (layer_done)   nxt = NEXT;
          else if (wd_last) nxt = ERROR;
        end
        NEXT:     nxt = last_layer ? FINISH : (load_q ? LOAD_ROW : CLEAR);
        FINISH:   nxt = IDLE;
        ERROR:    nxt = ERROR;
        default:  nxt = IDLE;
      endcase
    end
  end

  // Row, layer and watchdog counters plus the latched load mode
  always_ff @(posedge clk or negedge rst_overall_n) begin
    if (!rst_overall_n) begin
      row_q   <= '0;
      layer_q <= '0;
      wd_q    <= '0;
      load_q  <= 1'b0;
    end else if (abort) begin
      row_q   <= '0;
      layer_q <= '0;
      wd_q    <= '0;
      load_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_q   <= '0;
            layer_q <= '0;
            load_q  <= load_weights;
          end
        end
        LOAD_GAP: row_q <= last_row ? '0 : row_q + RW'(1);
        CLEAR:    wd_q  <= '0;
        COMPUTE:  wd_q  <= wd_q + WW'(1);
        NEXT:     if (!last_layer) layer_q <= layer_q + LW'(1);
        default:  ;
      endcase
    end
  end

  // Output decode; train_en is the accepted-handshake strobe in LOAD_ROW
  always_comb begin
    wt_ready    = 1'b0;
    train_en    = 1'b0;
    rst_vals    = 1'b0;
    en          = 1'b0;
    busy        = 1'b1;
    run_done    = 1'b0;
    timeout_err = 1'b0;
    row_sel     = row_q;
    layer_idx   = layer_q;
    case (state)
      IDLE:     busy = 1'b0;
      LOAD_ROW: begin
        wt_ready = 1'b1;
        train_en = wt_valid;
      end
      CLEAR:    rst_vals = 1'b1;
      COMPUTE:  en = 1'b1;
      FINISH:   run_done = 1'b1;
      ERROR: begin
        busy        = 1'b0;
        timeout_err = 1'b1;
      end
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer (ROWS=4, NUM_LAYERS=2, TIMEOUT=16).
module tb_layer_sequencer;

  logic       clk;
  logic       rst_overall_n;
  logic       start;
  logic       load_weights;
  logic       abort;
  logic       wt_valid;
  logic       wt_ready;
  logic       layer_done;
  logic [1:0] row_sel;
  logic       train_en;
  logic       rst_vals;
  logic       en;
  logic [0:0] layer_idx;
  logic       busy;
  logic       run_done;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int excl_err = 0;

  layer_sequencer #(
    .NUM_LAYERS(2),
    .ROWS      (4),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .rst_overall_n(rst_overall_n),
    .start        (start),
    .load_weights (load_weights),
    .abort        (abort),
    .wt_valid     (wt_valid),
    .wt_ready     (wt_ready),
    .layer_done   (layer_done),
    .row_sel      (row_sel),
    .train_en     (train_en),
    .rst_vals     (rst_vals),
    .en           (en),
    .layer_idx    (layer_idx),
    .busy         (busy),
    .run_done     (run_done),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count run_done pulses and strobe overlaps, sampled away from the rising edge
  always @(negedge clk) begin
    if (run_done) rd_cnt++;
    if ((int'(train_en) + int'(rst_vals) + int'(en)) > 1) excl_err++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_overall_n = 1'b0;
    start = 1'b0; load_weights = 1'b0; abort = 1'b0;
    wt_valid = 1'b0; layer_done = 1'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_en", en, 0);
    check("rst_rst_vals", rst_vals, 0);
    check("rst_train_en", train_en, 0);
    check("rst_layer_idx", layer_idx, 0);
    check("rst_row_sel", row_sel, 0);
    check("rst_run_done", run_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    #9 rst_overall_n = 1'b1;
    cyc(); cyc();

    // Run without weight load, two layers of 9 compute cycles each
    start = 1'b1; load_weights = 1'b0;
    cyc();
    start = 1'b0;
    check("t1_clear_rst_vals", rst_vals, 1);
    check("t1_clear_busy", busy, 1);
    check("t1_clear_en", en, 0);
    check("t1_clear_idx", layer_idx, 0);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 8; i++) begin
        cyc();
        check("t1_compute_en", en, 1);
        check("t1_compute_rst_vals", rst_vals, 0);
      end
      cyc();
      check("t1_compute9_en", en, 1);
      layer_done = 1'b1;
      cyc();
      layer_done = 1'b0;
      check("t1_next_en", en, 0);
      check("t1_next_busy", busy, 1);
      check("t1_next_idx", layer_idx, l);
      cyc();
      if (l == 0) begin
        check("t1_clear1_rst_vals", rst_vals, 1);
        check("t1_clear1_idx", layer_idx, 1);
      end else begin
        check("t1_finish_run_done", run_done, 1);
        check("t1_finish_busy", busy, 1);
        cyc();
        check("t1_idle_run_done", run_done, 0);
        check("t1_idle_busy", busy, 0);
      end
    end
    check("t1_run_done_count", rd_cnt, 1);

    // Weight load on every layer; layer 1 withholds wt_valid at row 2
    wt_valid = 1'b1; load_weights = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int l = 0; l < 2; l++) begin
      for (int r = 0; r < 4; r++) begin
        if (l == 1 && r == 2) begin
          for (int k = 0; k < 5; k++) begin
            check("t3_hold_wt_ready", wt_ready, 1);
            check("t3_hold_train_en", train_en, 0);
            check("t3_hold_row_sel", row_sel, 2);
            cyc();
          end
          wt_valid = 1'b1;
          #1;
        end
        check("t2_load_wt_ready", wt_ready, 1);
        check("t2_load_train_en", train_en, 1);
        check("t2_load_row_sel", row_sel, r);
        check("t2_load_idx", layer_idx, l);
        cyc();
        check("t2_gap_train_en", train_en, 0);
        check("t2_gap_wt_ready", wt_ready, 0);
        if (l == 1 && r == 1) wt_valid = 1'b0;
        cyc();
      end
      check("t2_clear_rst_vals", rst_vals, 1);
      cyc();
      check("t2_compute_en", en, 1);
      layer_done = 1'b1;
      cyc();
      layer_done = 1'b0;
      check("t2_next_en", en, 0);
      cyc();
    end
    check("t2_finish_run_done", run_done, 1);
    cyc();
    check("t2_idle_busy", busy, 0);
    check("t2_run_done_count", rd_cnt, 2);
    wt_valid = 1'b0; load_weights = 1'b0;

    // Watchdog expiry, start ignored while busy and in ERROR, abort recovery
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    for (int i = 0; i < 16; i++) begin
      check("t4_compute_en", en, 1);
      if (i == 3) start = 1'b1;
      cyc();
      start = 1'b0;
    end
    check("t4_err_timeout", timeout_err, 1);
    check("t4_err_busy", busy, 0);
    check("t4_err_en", en, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("t4_err_start_ignored", timeout_err, 1);
    check("t4_err_rst_vals", rst_vals, 0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t4_abort_timeout", timeout_err, 0);
    check("t4_abort_busy", busy, 0);

    // layer_done coincides with the last watchdog cycle, then abort in layer-1 compute
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    repeat (15) cyc();
    check("t5_last_wd_en", en, 1);
    layer_done = 1'b1;
    cyc();
    layer_done = 1'b0;
    check("t5_next_timeout", timeout_err, 0);
    check("t5_next_busy", busy, 1);
    check("t5_next_en", en, 0);
    cyc();
    cyc();
    check("t6_l1_en", en, 1);
    check("t6_l1_idx", layer_idx, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t6_abort_en", en, 0);
    check("t6_abort_idx", layer_idx, 0);
    check("t6_abort_busy", busy, 0);
    check("t6_abort_rst_vals", rst_vals, 0);

    // Asynchronous reset during layer-1 compute, no resume until a fresh start
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    layer_done = 1'b1;
    cyc();
    layer_done = 1'b0;
    cyc();
    cyc();
    check("t7_l1_en", en, 1);
    check("t7_l1_idx", layer_idx, 1);
    #1 rst_overall_n = 1'b0;
    #1;
    check("t7_rst_en", en, 0);
    check("t7_rst_idx", layer_idx, 0);
    check("t7_rst_busy", busy, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("t7_rst_held_busy", busy, 0);
    rst_overall_n = 1'b1;
    cyc();
    check("t7_release_busy", busy, 0);
    check("t7_release_en", en, 0);
    check("t7_run_done_count", rd_cnt, 2);
    check("strobe_exclusive", excl_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
